// File: rtl/lsu_wb_if.sv
// ============================================================================
// lsu_wb_if : execute-stage, AXI-lite master and register-file port bundle
// Revision  : 1.0
// ============================================================================
`default_nettype none

interface lsu_wb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_alu_result;
  logic [4:0]        in_rd;
  logic              in_rf_wen;
  logic              in_mem_ren;
  logic              in_mem_wen;
  logic [2:0]        in_funct3;
  logic [DATA_W-1:0] in_store_data;

  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  logic [DATA_W-1:0] rf_wdata;
  logic [4:0]        rf_waddr;
  logic              rf_wen;
  logic              wb_done;
  logic              access_fault;

  modport master (
    input  in_valid, in_alu_result, in_rd, in_rf_wen, in_mem_ren, in_mem_wen,
           in_funct3, in_store_data,
           arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid,
    output in_ready, araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb,
           wvalid, bready, rf_wdata, rf_waddr, rf_wen, wb_done, access_fault
  );

  modport slave (
    output in_valid, in_alu_result, in_rd, in_rf_wen, in_mem_ren, in_mem_wen,
           in_funct3, in_store_data,
           arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid,
    input  in_ready, araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb,
           wvalid, bready, rf_wdata, rf_waddr, rf_wen, wb_done, access_fault
  );
endinterface

`default_nettype wire

// File: rtl/lsu_wb.sv
// ============================================================================
// lsu_wb   : RV32 memory-access / writeback stage, AXI-lite master
// Revision : 1.0
// ============================================================================
`default_nettype none

module lsu_wb #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic      clk,
  input  logic      rst,
  lsu_wb_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_ADDR = 3'd1,
    S_RD_DATA = 3'd2,
    S_WR_REQ  = 3'd3,
    S_WR_RESP = 3'd4,
    S_WB      = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic [4:0]        rd_q, rd_d;
  logic              rf_wen_q, rf_wen_d;
  logic              mem_ren_q, mem_ren_d;
  logic              mem_wen_q, mem_wen_d;
  logic [2:0]        funct3_q, funct3_d;
  logic              fault_q, fault_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              arvalid_q, arvalid_d;
  logic              rready_q, rready_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic              bready_q, bready_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;

  logic [1:0]        in_off;
  logic              in_misaligned;
  logic [3:0]        in_strb;
  logic [DATA_W-1:0] ld_shift;
  logic [DATA_W-1:0] ld_data;

  assign in_off = bus.in_alu_result[1:0];

  // funct3[1:0] encodes the access size: 00 byte, 01 half, 1x word.
  always_comb begin
    in_misaligned = 1'b0;
    in_strb       = 4'b1111;
    case (bus.in_funct3[1:0])
      2'b00: in_strb = 4'b0001 << in_off;
      2'b01: begin
        in_strb       = 4'b0011 << in_off;
        in_misaligned = in_off[0];
      end
      default: in_misaligned = (in_off != 2'b00);
    endcase
  end

  assign ld_shift = rdata_q >> {alu_q[1:0], 3'b000};

  always_comb begin
    ld_data = rdata_q;
    case (funct3_q)
      3'b000:  ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
      3'b001:  ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
      3'b100:  ld_data = {24'b0, ld_shift[7:0]};
      3'b101:  ld_data = {16'b0, ld_shift[15:0]};
      default: ld_data = rdata_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    alu_d     = alu_q;
    rd_d      = rd_q;
    rf_wen_d  = rf_wen_q;
    mem_ren_d = mem_ren_q;
    mem_wen_d = mem_wen_q;
    funct3_d  = funct3_q;
    fault_d   = fault_q;
    rdata_d   = rdata_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    araddr_d  = araddr_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          alu_d     = bus.in_alu_result;
          rd_d      = bus.in_rd;
          rf_wen_d  = bus.in_rf_wen;
          mem_ren_d = bus.in_mem_ren;
          mem_wen_d = bus.in_mem_wen;
          funct3_d  = bus.in_funct3;
          fault_d   = 1'b0;
          // Bus address/data are computed here so every AXI output is a flop.
          araddr_d  = {bus.in_alu_result[ADDR_W-1:2], 2'b00};
          awaddr_d  = {bus.in_alu_result[ADDR_W-1:2], 2'b00};
          wdata_d   = bus.in_store_data << {in_off, 3'b000};
          wstrb_d   = in_strb;
          if ((bus.in_mem_ren || bus.in_mem_wen) && in_misaligned) begin
            fault_d = 1'b1;
            state_d = S_WB;
          end else if (bus.in_mem_ren) begin
            arvalid_d = 1'b1;
            state_d   = S_RD_ADDR;
          end else if (bus.in_mem_wen) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = S_WR_REQ;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_RD_ADDR: begin
        if (bus.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        if (bus.rvalid) begin
          rdata_d  = bus.rdata;
          fault_d  = (bus.rresp != 2'b00);
          rready_d = 1'b0;
          state_d  = S_WB;
        end
      end
      S_WR_REQ: begin
        awvalid_d = awvalid_q && !bus.awready;
        wvalid_d  = wvalid_q && !bus.wready;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = S_WR_RESP;
        end
      end
      S_WR_RESP: begin
        if (bus.bvalid) begin
          fault_d  = (bus.bresp != 2'b00);
          bready_d = 1'b0;
          state_d  = S_WB;
        end
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      alu_q     <= '0;
      rd_q      <= '0;
      rf_wen_q  <= 1'b0;
      mem_ren_q <= 1'b0;
      mem_wen_q <= 1'b0;
      funct3_q  <= '0;
      fault_q   <= 1'b0;
      rdata_q   <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      araddr_q  <= '0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      state_q   <= state_d;
      alu_q     <= alu_d;
      rd_q      <= rd_d;
      rf_wen_q  <= rf_wen_d;
      mem_ren_q <= mem_ren_d;
      mem_wen_q <= mem_wen_d;
      funct3_q  <= funct3_d;
      fault_q   <= fault_d;
      rdata_q   <= rdata_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      araddr_q  <= araddr_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
    end
  end

  assign bus.in_ready     = (state_q == S_IDLE);
  assign bus.araddr       = araddr_q;
  assign bus.arvalid      = arvalid_q;
  assign bus.rready       = rready_q;
  assign bus.awaddr       = awaddr_q;
  assign bus.awvalid      = awvalid_q;
  assign bus.wdata        = wdata_q;
  assign bus.wstrb        = wstrb_q;
  assign bus.wvalid       = wvalid_q;
  assign bus.bready       = bready_q;
  assign bus.wb_done      = (state_q == S_WB);
  assign bus.access_fault = (state_q == S_WB) && fault_q;
  // Stores never write the register file, even if rf_wen was set upstream.
  assign bus.rf_wen       = (state_q == S_WB) && rf_wen_q && !mem_wen_q && !fault_q;
  assign bus.rf_waddr     = rd_q;
  assign bus.rf_wdata     = mem_ren_q ? ld_data : alu_q;

endmodule

`default_nettype wire

// File: tb/tb_lsu_wb.sv
// ============================================================================
// tb_lsu_wb : randomized self-checking bench for lsu_wb with an AXI-lite slave
// Revision  : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_lsu_wb;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  lsu_wb_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  lsu_wb #(.ADDR_W(32), .DATA_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        rfw, ren, wen;
    logic [2:0]  f3;
    logic [31:0] sd, rdat;
    logic [1:0]  rresp, bresp;
    int          ar_d, r_d, aw_d, w_d, b_d;
  } op_t;

  typedef struct {
    logic        acc_rdy, done, rfw, flt, rdy_wb, unstable, bus_any;
    int          lat, ar_n, aw_n, w_n;
    logic [4:0]  waddr;
    logic [31:0] rf_data, araddr, awaddr, wdata;
    logic [3:0]  wstrb;
  } obs_t;

  typedef struct {
    logic        fault, rfw;
    int          lat, ar_n, aw_n, w_n;
    logic [31:0] rf_data, addr, wdata;
    logic [3:0]  wstrb;
  } exp_t;

  // Reference model: what the stage must do, from the ISA/AXI rules.
  function automatic exp_t model(op_t op);
    exp_t        e;
    int          off, sz, b, h;
    logic        mem, mis;
    logic [31:0] word;
    off  = int'(op.alu[1:0]);
    sz   = (op.f3[1:0] == 2'd0) ? 1 : (op.f3[1:0] == 2'd1) ? 2 : 4;
    mem  = op.ren || op.wen;
    mis  = mem && ((off % sz) != 0);
    e.fault = mis || (op.ren && op.rresp != 0) || (op.wen && op.bresp != 0);
    e.rfw   = op.rfw && !op.wen && !e.fault;
    word = op.rdat >> (8 * off);
    b    = int'(word % 256);
    h    = int'(word % 65536);
    case (op.f3)
      3'd0:    e.rf_data = (b >= 128) ? 32'(b - 256) : 32'(b);
      3'd1:    e.rf_data = (h >= 32768) ? 32'(h - 65536) : 32'(h);
      3'd4:    e.rf_data = 32'(b);
      3'd5:    e.rf_data = 32'(h);
      default: e.rf_data = op.rdat;
    endcase
    if (!op.ren) e.rf_data = op.alu;
    e.lat  = 1;
    e.ar_n = 0; e.aw_n = 0; e.w_n = 0;
    if (op.ren && !mis) begin
      e.lat  = 3 + op.ar_d + op.r_d;
      e.ar_n = op.ar_d + 1;
    end
    if (op.wen && !mis) begin
      e.lat  = 3 + ((op.aw_d > op.w_d) ? op.aw_d : op.w_d) + op.b_d;
      e.aw_n = op.aw_d + 1;
      e.w_n  = op.w_d + 1;
    end
    e.addr  = op.alu - 32'(off);
    e.wdata = op.sd * (32'd1 << (8 * off));
    e.wstrb = (sz == 4) ? 4'hF : 4'(((1 << sz) - 1) << off);
    return e;
  endfunction

  function automatic op_t rand_op(int kind);
    op_t op;
    int  sel;
    op.alu   = $urandom;
    op.rd    = 5'($urandom);
    op.rfw   = 1'($urandom);
    op.ren   = (kind == 1);
    op.wen   = (kind == 2);
    op.sd    = $urandom;
    op.rdat  = $urandom;
    op.rresp = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
    op.bresp = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
    op.ar_d  = $urandom_range(0, 3);
    op.r_d   = $urandom_range(0, 3);
    op.aw_d  = $urandom_range(0, 3);
    op.w_d   = $urandom_range(0, 3);
    op.b_d   = $urandom_range(0, 3);
    sel      = $urandom_range(0, 4);
    op.f3    = (kind == 0) ? 3'($urandom) :
               (sel == 3) ? 3'd4 : (sel == 4) ? ((kind == 1) ? 3'd5 : 3'd2) : 3'(sel);
    return op;
  endfunction

  // Presents one instruction and plays the AXI-lite slave until writeback.
  task automatic run_op(input op_t op, output obs_t o);
    int ar_k, r_k, aw_k, w_k, b_k;
    o = '{default: 0};
    ar_k = 0; r_k = 0; aw_k = 0; w_k = 0; b_k = 0;
    @(negedge clk);
    o.acc_rdy = bus.in_ready;
    bus.in_valid      = 1'b1;
    bus.in_alu_result = op.alu;
    bus.in_rd         = op.rd;
    bus.in_rf_wen     = op.rfw;
    bus.in_mem_ren    = op.ren;
    bus.in_mem_wen    = op.wen;
    bus.in_funct3     = op.f3;
    bus.in_store_data = op.sd;
    @(negedge clk);
    bus.in_valid      = 1'b0;
    bus.in_alu_result = $urandom;
    bus.in_rd         = 5'($urandom);
    bus.in_funct3     = 3'($urandom);
    bus.in_store_data = $urandom;
    for (int cyc = 1; cyc <= 64 && !o.done; cyc++) begin
      if (bus.wb_done) begin
        o.done    = 1'b1;
        o.lat     = cyc;
        o.rfw     = bus.rf_wen;
        o.flt     = bus.access_fault;
        o.waddr   = bus.rf_waddr;
        o.rf_data = bus.rf_wdata;
        o.rdy_wb  = bus.in_ready;
      end else begin
        o.bus_any = o.bus_any | bus.arvalid | bus.awvalid | bus.wvalid;
        if (bus.arvalid) begin
          o.ar_n++;
          if (o.ar_n == 1) o.araddr = bus.araddr;
          else if (bus.araddr !== o.araddr) o.unstable = 1'b1;
          bus.arready = (ar_k == op.ar_d); ar_k++;
        end else bus.arready = 1'b0;
        if (bus.rready) begin
          bus.rvalid = (r_k == op.r_d); r_k++;
          bus.rdata  = bus.rvalid ? op.rdat : $urandom;
          bus.rresp  = bus.rvalid ? op.rresp : 2'($urandom);
        end else bus.rvalid = 1'b0;
        if (bus.awvalid) begin
          o.aw_n++;
          if (o.aw_n == 1) o.awaddr = bus.awaddr;
          else if (bus.awaddr !== o.awaddr) o.unstable = 1'b1;
          bus.awready = (aw_k == op.aw_d); aw_k++;
        end else bus.awready = 1'b0;
        if (bus.wvalid) begin
          o.w_n++;
          if (o.w_n == 1) begin o.wdata = bus.wdata; o.wstrb = bus.wstrb; end
          else if (bus.wdata !== o.wdata || bus.wstrb !== o.wstrb) o.unstable = 1'b1;
          bus.wready = (w_k == op.w_d); w_k++;
        end else bus.wready = 1'b0;
        if (bus.bready) begin
          bus.bvalid = (b_k == op.b_d); b_k++;
          bus.bresp  = bus.bvalid ? op.bresp : 2'($urandom);
        end else bus.bvalid = 1'b0;
        @(negedge clk);
      end
    end
    bus.arready = 1'b0; bus.rvalid = 1'b0; bus.awready = 1'b0;
    bus.wready  = 1'b0; bus.bvalid = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    n_vec++;
    if ({bus.in_ready, bus.arvalid, bus.awvalid, bus.wvalid, bus.rready, bus.bready} !== 6'b100000) begin
      n_err++; $display("FAIL reset_handshake: got %b want 100000",
        {bus.in_ready, bus.arvalid, bus.awvalid, bus.wvalid, bus.rready, bus.bready});
    end
    n_vec++;
    if ({bus.rf_wen, bus.wb_done, bus.access_fault} !== 3'b000) begin
      n_err++; $display("FAIL reset_wb: got %b want 000", {bus.rf_wen, bus.wb_done, bus.access_fault});
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_alu();
    op_t op; obs_t o; exp_t e;
    op = rand_op(0);
    op.alu = 32'h12345678; op.rd = 5'd5; op.rfw = 1'b1; op.f3 = 3'd0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) op = rand_op(0);
      e = model(op);
      run_op(op, o);
      n_vec++;
      if (!o.done || o.lat !== e.lat || o.bus_any) begin
        n_err++; $display("FAIL alu_latency[%0d]: got done=%b lat=%0d bus=%b want lat=%0d bus=0", i, o.done, o.lat, o.bus_any, e.lat);
      end
      n_vec++;
      if ({o.rfw, o.flt, o.waddr} !== {e.rfw, 1'b0, op.rd}) begin
        n_err++; $display("FAIL alu_rf_ctl[%0d]: got wen=%b flt=%b rd=%0d want %b 0 %0d", i, o.rfw, o.flt, o.waddr, e.rfw, op.rd);
      end
      n_vec++;
      if (o.rf_data !== op.alu) begin
        n_err++; $display("FAIL alu_rf_data[%0d]: got %h want %h", i, o.rf_data, op.alu);
      end
    end
  endtask

  task automatic test_load();
    op_t op; obs_t o; exp_t e;
    for (int i = 0; i < 22; i++) begin
      op = rand_op(1);
      if (i < 2) begin
        op.alu = 32'h80000003; op.rdat = 32'h80FF0000; op.rresp = 2'd0; op.rfw = 1'b1;
        op.ar_d = 2; op.r_d = 2; op.f3 = (i == 0) ? 3'd0 : 3'd4;
      end else begin
        op.alu[1:0] = (op.f3[1:0] == 2'd0) ? op.alu[1:0] : (op.f3[1:0] == 2'd1) ? {op.alu[1], 1'b0} : 2'd0;
      end
      e = model(op);
      run_op(op, o);
      n_vec++;
      if (!o.done || o.lat !== e.lat || o.ar_n !== e.ar_n || o.unstable) begin
        n_err++; $display("FAIL load_timing[%0d]: got lat=%0d ar=%0d unst=%b want lat=%0d ar=%0d", i, o.lat, o.ar_n, o.unstable, e.lat, e.ar_n);
      end
      n_vec++;
      if (o.araddr !== e.addr || o.aw_n != 0) begin
        n_err++; $display("FAIL load_araddr[%0d]: got %h aw=%0d want %h aw=0", i, o.araddr, o.aw_n, e.addr);
      end
      n_vec++;
      if ({o.rfw, o.flt, o.waddr} !== {e.rfw, e.fault, op.rd}) begin
        n_err++; $display("FAIL load_rf_ctl[%0d]: got %b %b %0d want %b %b %0d", i, o.rfw, o.flt, o.waddr, e.rfw, e.fault, op.rd);
      end
      if (e.rfw) begin
        n_vec++;
        if (o.rf_data !== e.rf_data) begin
          n_err++; $display("FAIL load_data[%0d] f3=%0d: got %h want %h", i, op.f3, o.rf_data, e.rf_data);
        end
      end
    end
  endtask

  task automatic test_store();
    op_t op; obs_t o; exp_t e;
    for (int i = 0; i < 20; i++) begin
      op = rand_op(2);
      if (i == 0) begin
        op.alu = 32'h80000002; op.sd = 32'h0000ABCD; op.f3 = 3'd1; op.rfw = 1'b1;
        op.aw_d = 0; op.w_d = 3; op.bresp = 2'd0;
      end else begin
        op.alu[1:0] = (op.f3[1:0] == 2'd0) ? op.alu[1:0] : (op.f3[1:0] == 2'd1) ? {op.alu[1], 1'b0} : 2'd0;
      end
      e = model(op);
      run_op(op, o);
      n_vec++;
      if (!o.done || o.lat !== e.lat || o.aw_n !== e.aw_n || o.w_n !== e.w_n || o.unstable) begin
        n_err++; $display("FAIL store_timing[%0d]: got lat=%0d aw=%0d w=%0d unst=%b want lat=%0d aw=%0d w=%0d", i, o.lat, o.aw_n, o.w_n, o.unstable, e.lat, e.aw_n, e.w_n);
      end
      n_vec++;
      if (o.awaddr !== e.addr || o.wdata !== e.wdata || o.wstrb !== e.wstrb || o.ar_n != 0) begin
        n_err++; $display("FAIL store_bus[%0d]: got a=%h d=%h s=%b want a=%h d=%h s=%b", i, o.awaddr, o.wdata, o.wstrb, e.addr, e.wdata, e.wstrb);
      end
      n_vec++;
      if ({o.rfw, o.flt} !== {1'b0, e.fault}) begin
        n_err++; $display("FAIL store_rf_ctl[%0d]: got wen=%b flt=%b want 0 %b", i, o.rfw, o.flt, e.fault);
      end
    end
  endtask

  task automatic test_misaligned();
    op_t op; obs_t o;
    for (int i = 0; i < 6; i++) begin
      op = rand_op((i % 2) + 1);
      op.f3 = (i < 2) ? 3'd2 : (i < 4) ? 3'd1 : 3'd5;
      if (op.wen && op.f3 == 3'd5) op.f3 = 3'd1;
      op.alu[1:0] = (i == 0) ? 2'd1 : (op.f3[1:0] == 2'd2) ? 2'd2 : 2'd3;
      if (i == 0) op.alu = 32'h80000001;
      run_op(op, o);
      n_vec++;
      if (!o.done || o.lat != 1 || o.bus_any || o.flt !== 1'b1 || o.rfw !== 1'b0) begin
        n_err++; $display("FAIL misaligned[%0d]: got lat=%0d bus=%b flt=%b wen=%b want 1 0 1 0", i, o.lat, o.bus_any, o.flt, o.rfw);
      end
    end
  endtask

  task automatic test_bus_error();
    op_t op; obs_t o;
    op = rand_op(1);
    op.alu = 32'h80000040; op.f3 = 3'd2; op.rfw = 1'b1; op.rresp = 2'b10;
    run_op(op, o);
    n_vec++;
    if (o.flt !== 1'b1 || o.rfw !== 1'b0 || !o.done) begin
      n_err++; $display("FAIL rresp_err: got flt=%b wen=%b want 1 0", o.flt, o.rfw);
    end
    op = rand_op(2);
    op.alu = 32'h80000044; op.f3 = 3'd2; op.bresp = 2'b11;
    run_op(op, o);
    n_vec++;
    if (o.flt !== 1'b1 || !o.done) begin
      n_err++; $display("FAIL bresp_err: got flt=%b want 1", o.flt);
    end
    op = rand_op(0);
    op.rfw = 1'b1;
    run_op(op, o);
    n_vec++;
    if (!o.acc_rdy || o.lat != 1 || o.flt !== 1'b0 || o.rfw !== 1'b1 || o.rf_data !== op.alu) begin
      n_err++; $display("FAIL after_err: got rdy=%b lat=%0d flt=%b wen=%b d=%h want 1 1 0 1 %h", o.acc_rdy, o.lat, o.flt, o.rfw, o.rf_data, op.alu);
    end
  endtask

  task automatic test_reset_midflight();
    op_t op; obs_t o;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_alu_result = 32'h80000010; bus.in_rd = 5'd3;
    bus.in_rf_wen = 1'b1; bus.in_mem_ren = 1'b1; bus.in_mem_wen = 1'b0; bus.in_funct3 = 3'd2;
    @(negedge clk);
    bus.in_valid = 1'b0; bus.arready = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({bus.arvalid, bus.in_ready} !== 2'b10) begin
      n_err++; $display("FAIL pre_reset_ar: got arvalid/in_ready=%b want 10", {bus.arvalid, bus.in_ready});
    end
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if ({bus.arvalid, bus.in_ready, bus.wb_done} !== 3'b010) begin
      n_err++; $display("FAIL async_reset: got arvalid/in_ready/wb_done=%b want 010", {bus.arvalid, bus.in_ready, bus.wb_done});
    end
    @(negedge clk);
    rst = 1'b0;
    op = rand_op(0);
    op.rfw = 1'b1; op.rd = 5'd9;
    run_op(op, o);
    n_vec++;
    if (!o.done || o.lat != 1 || o.rfw !== 1'b1 || o.waddr !== 5'd9 || o.rf_data !== op.alu) begin
      n_err++; $display("FAIL post_reset_add: got lat=%0d wen=%b rd=%0d d=%h want 1 1 9 %h", o.lat, o.rfw, o.waddr, o.rf_data, op.alu);
    end
  endtask

  task automatic test_back_to_back();
    op_t op; obs_t o; exp_t e;
    for (int i = 0; i < 30; i++) begin
      op = rand_op($urandom_range(0, 2));
      e = model(op);
      run_op(op, o);
      n_vec++;
      if (!o.acc_rdy || o.rdy_wb !== 1'b0 || !o.done || o.lat !== e.lat) begin
        n_err++; $display("FAIL b2b_flow[%0d]: got rdy=%b rdy_wb=%b lat=%0d want 1 0 %0d", i, o.acc_rdy, o.rdy_wb, o.lat, e.lat);
      end
      n_vec++;
      if ({o.rfw, o.flt, o.waddr} !== {e.rfw, e.fault, op.rd} || (e.rfw && o.rf_data !== e.rf_data)) begin
        n_err++; $display("FAIL b2b_rf[%0d]: got %b %b %0d %h want %b %b %0d %h", i, o.rfw, o.flt, o.waddr, o.rf_data, e.rfw, e.fault, op.rd, e.rf_data);
      end
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_alu_result = '0; bus.in_rd = '0; bus.in_rf_wen = 1'b0;
    bus.in_mem_ren = 1'b0; bus.in_mem_wen = 1'b0; bus.in_funct3 = '0; bus.in_store_data = '0;
    bus.arready = 1'b0; bus.rdata = '0; bus.rresp = '0; bus.rvalid = 1'b0;
    bus.awready = 1'b0; bus.wready = 1'b0; bus.bresp = '0; bus.bvalid = 1'b0;
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_misaligned();
    test_bus_error();
    test_reset_midflight();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
